test_cfg_ctrl: RTL and testbench

//  Configuration controller for the TOP-level test MUX/DEMUX network.

---
 rtl/test_cfg_ctrl.sv | 123 ++++++++++++
 tb/tb_test_cfg_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/test_cfg_ctrl.sv
// Serial-loaded test select controller with parity check and a
// blank / switch / settle sequence around every select update.
module test_cfg_ctrl #(
   parameter int          GUARD_CYCLES  = 4,
   parameter int          SETTLE_CYCLES = 8,
   parameter logic [16:0] DEFAULT_CFG   = 17'h0
) (
   input  logic       inClock,
   input  logic       inReset,
   input  logic       inCfgSerial,
   input  logic       inCfgShift,
   input  logic       inCfgLoad,
   output logic [2:0] outSel1,
   output logic [2:0] outSel2,
   output logic       outSel3,
   output logic [1:0] outSel6,
   output logic [1:0] outSel9,
   output logic       outSel11,
   output logic       outSel12,
   output logic [2:0] outSel15,
   output logic       outSel17,
   output logic       outBlankN,
   output logic       outBusy,
   output logic       outCfgError
);

   localparam int MAXC = (GUARD_CYCLES > SETTLE_CYCLES) ?
                         GUARD_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GUARD,
      S_APPLY,
      S_SETTLE
   } state_t;

   state_t         r_state;
   logic [17:0]    r_sr;
   logic [4:0]     r_cnt;
   logic [16:0]    r_shadow;
   logic [16:0]    r_sel;
   logic [TW-1:0]  r_tmr;
   logic           r_blank_n;
   logic           r_busy;
   logic           r_err;
   logic           w_valid;

   // odd parity over all 18 bits, and exactly 18 bits received
   assign w_valid = (r_cnt == 5'd18) && (^r_sr);

   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_cnt     <= '0;
         r_shadow  <= DEFAULT_CFG;
         r_sel     <= DEFAULT_CFG;
         r_tmr     <= '0;
         r_blank_n <= 1'b1;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_blank_n <= (r_state == S_IDLE);
         r_busy    <= (r_state != S_IDLE);
         unique case (r_state)
            S_IDLE: begin
               if (inCfgLoad) begin
                  r_cnt <= '0;
                  if (w_valid) begin
                     r_shadow <= r_sr[16:0];
                     r_err    <= 1'b0;
                     r_tmr    <= '0;
                     r_state  <= S_GUARD;
                  end else begin
                     r_err <= 1'b1;
                  end
               end else if (inCfgShift) begin
                  r_sr <= {r_sr[16:0], inCfgSerial};
                  if (r_cnt != 5'd31)
                     r_cnt <= r_cnt + 5'd1;
               end
            end
            S_GUARD: begin
               if (r_tmr == TW'(GUARD_CYCLES - 1)) begin
                  r_tmr   <= '0;
                  r_state <= S_APPLY;
               end else begin
                  r_tmr <= r_tmr + TW'(1);
               end
            end
            S_APPLY: begin
               r_sel   <= r_shadow;
               r_tmr   <= '0;
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (r_tmr == TW'(SETTLE_CYCLES - 1)) begin
                  r_tmr   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr + TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign outSel1     = r_sel[16:14];
   assign outSel2     = r_sel[13:11];
   assign outSel3     = r_sel[10];
   assign outSel6     = r_sel[9:8];
   assign outSel9     = r_sel[7:6];
   assign outSel11    = r_sel[5];
   assign outSel12    = r_sel[4];
   assign outSel15    = r_sel[3:1];
   assign outSel17    = r_sel[0];
   assign outBlankN   = r_blank_n;
   assign outBusy     = r_busy;
   assign outCfgError = r_err;

endmodule

// File: tb/tb_test_cfg_ctrl.sv
// Directed bench for test_cfg_ctrl: vector table of loads plus
// hand sequences for lockout, shift+load and mid-sequence reset.
module tb_test_cfg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser = 1'b0;
   logic       sh = 1'b0;
   logic       ld = 1'b0;
   logic [2:0] s1, s2, s15;
   logic [1:0] s6, s9;
   logic       s3, s11, s12, s17;
   logic       blank_n, busy, err;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   test_cfg_ctrl dut (
      .inClock     (clk),
      .inReset     (rst_n),
      .inCfgSerial (ser),
      .inCfgShift  (sh),
      .inCfgLoad   (ld),
      .outSel1     (s1),
      .outSel2     (s2),
      .outSel3     (s3),
      .outSel6     (s6),
      .outSel9     (s9),
      .outSel11    (s11),
      .outSel12    (s12),
      .outSel15    (s15),
      .outSel17    (s17),
      .outBlankN   (blank_n),
      .outBusy     (busy),
      .outCfgError (err)
   );

   localparam logic [17:0] W_T2 = 18'b1_101_010_1_10_01_1_0_011_1;
   localparam logic [17:0] W_P  = 18'b0_101_010_1_10_01_1_0_011_1;
   localparam logic [17:0] W_2  = 18'b0_011_111_0_11_10_0_1_110_0;

   typedef struct {
      logic [18:0] bits;
      int          n;
      logic        ok;
   } vec_t;

   vec_t        tbl[7];
   logic [16:0] m_sel;

   function automatic logic [16:0] sel_cat();
      return {s1, s2, s3, s6, s9, s11, s12, s15, s17};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input logic [18:0] b, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sh  = 1'b1;
         ser = b[i];
         tick();
      end
      sh  = 1'b0;
      ser = 1'b0;
   endtask

   task automatic pulse_load();
      ld = 1'b1;
      tick();
      ld = 1'b0;
   endtask

   // called right after the load edge N; checks edges N+1 .. N+16
   task automatic run_seq(input string nm, input logic [16:0] old_sel,
                          input logic [16:0] new_sel);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("%s_sel_k%0d", nm, k), 32'(sel_cat()),
             32'((k >= 5) ? new_sel : old_sel));
         chk($sformatf("%s_blank_k%0d", nm, k), 32'(blank_n),
             32'((k <= 13) ? 1'b0 : 1'b1));
         chk($sformatf("%s_busy_k%0d", nm, k), 32'(busy),
             32'((k <= 13) ? 1'b1 : 1'b0));
      end
   endtask

   initial begin
      tbl[0] = '{bits: {1'b0, W_T2},        n: 18, ok: 1'b1};
      tbl[1] = '{bits: {1'b0, W_P},         n: 18, ok: 1'b0};
      tbl[2] = '{bits: {1'b0, W_2},         n: 18, ok: 1'b1};
      tbl[3] = '{bits: {2'b00, W_2[16:0]},  n: 17, ok: 1'b0};
      tbl[4] = '{bits: {1'b1, W_T2},        n: 19, ok: 1'b0};
      tbl[5] = '{bits: {1'b0, W_T2},        n: 18, ok: 1'b1};
      tbl[6] = '{bits: {1'b0, W_T2},        n: 18, ok: 1'b1};
      m_sel = 17'h0;

      #12;
      chk("rst_sel", 32'(sel_cat()), 32'(17'h0));
      chk("rst_blank", 32'(blank_n), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         shift_bits(tbl[i].bits, tbl[i].n);
         pulse_load();
         chk($sformatf("v%0d_err", i), 32'(err), 32'(!tbl[i].ok));
         if (tbl[i].ok) begin
            run_seq($sformatf("v%0d", i), m_sel, tbl[i].bits[16:0]);
            m_sel = tbl[i].bits[16:0];
         end else begin
            for (int k = 1; k <= 3; k++) begin
               tick();
               chk($sformatf("v%0d_sel_k%0d", i, k), 32'(sel_cat()),
                   32'(m_sel));
               chk($sformatf("v%0d_blank_k%0d", i, k), 32'(blank_n), 32'd1);
               chk($sformatf("v%0d_busy_k%0d", i, k), 32'(busy), 32'd0);
            end
         end
         if (i == 0) begin
            chk("t2_sel1", 32'(s1), 32'd5);
            chk("t2_sel2", 32'(s2), 32'd2);
            chk("t2_sel3", 32'(s3), 32'd1);
            chk("t2_sel6", 32'(s6), 32'd2);
            chk("t2_sel9", 32'(s9), 32'd1);
            chk("t2_sel11", 32'(s11), 32'd1);
            chk("t2_sel12", 32'(s12), 32'd0);
            chk("t2_sel15", 32'(s15), 32'd3);
            chk("t2_sel17", 32'(s17), 32'd1);
         end
      end

      // shift and load on the same cycle after a full word
      shift_bits({1'b0, W_2}, 18);
      sh  = 1'b1;
      ser = 1'b1;
      ld  = 1'b1;
      tick();
      sh  = 1'b0;
      ld  = 1'b0;
      ser = 1'b0;
      chk("t6_err", 32'(err), 32'd0);
      run_seq("t6", m_sel, W_2[16:0]);
      m_sel = W_2[16:0];

      // shifts and loads during the sequence must be ignored
      shift_bits({1'b0, W_T2}, 18);
      pulse_load();
      for (int k = 1; k <= 12; k++) begin
         sh  = 1'b1;
         ser = k[0];
         ld  = (k == 3 || k == 10);
         tick();
      end
      sh  = 1'b0;
      ld  = 1'b0;
      ser = 1'b0;
      tick();
      tick();
      chk("t5_blank", 32'(blank_n), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_sel", 32'(sel_cat()), 32'(W_T2[16:0]));
      chk("t5_err", 32'(err), 32'd0);
      m_sel = W_T2[16:0];
      shift_bits({1'b0, W_2}, 18);
      pulse_load();
      chk("t5b_err", 32'(err), 32'd0);
      run_seq("t5b", m_sel, W_2[16:0]);
      m_sel = W_2[16:0];

      // reset in the middle of SETTLE
      shift_bits({1'b0, W_T2}, 18);
      pulse_load();
      for (int k = 1; k <= 9; k++) tick();
      chk("t1_pre_sel", 32'(sel_cat()), 32'(W_T2[16:0]));
      chk("t1_pre_blank", 32'(blank_n), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_sel", 32'(sel_cat()), 32'(17'h0));
      chk("t1_blank", 32'(blank_n), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_err", 32'(err), 32'd0);
      #2;
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("t1_post_sel_k%0d", k), 32'(sel_cat()), 32'(17'h0));
         chk($sformatf("t1_post_blank_k%0d", k), 32'(blank_n), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
